enigma_step_controller: RTL and testbench
=========================================

# enigma_step_controller

Sequencing controller for the Enigma cipher datapath. Sits between the keyboard decoder (one-hot `letter` plus `ready`) and the rotor/reflector chain. It detects each new key press, advances three rotor positions with Enigma odometer and double-step rules, and presents the letter index to the datapath. After a programmable settle time it captures the enciphered letter and issues a one-cycle result strobe to the display.

## Interface
Parameters:
- `NOTCH_R`, default 16: right-rotor position at which the middle rotor is carried.
- `NOTCH_M`, default 4: middle-rotor position at which the left rotor is carried; also the double-step position.
- `SETTLE`, default 2: cycles the datapath input is held before capture. Legal range 1..15.

Ports (clock and reset first):
- `clock  in  1`: single clock (CLOCK_50 domain).
- `reset  in  1`: asynchronous, active-high.
- `key_in  in  26`: one-hot letter from the keyboard decoder. Bit 0 = A.
- `key_ready  in  1`: keyboard make/break level (high = key held).
- `cfg_load  in  1`: load rotor start positions.
- `cfg_pos  in  15`: start positions {L[14:10], M[9:5], R[4:0]}.
- `pos_l`, `pos_m`, `pos_r  out  5 each`: current rotor positions, 0..25.
- `cipher_in  out  5`: letter index driven to the datapath.
- `cipher_valid  out  1`: high while `cipher_in` is meaningful (SETTLE and CAPTURE states).
- `cipher_out  in  5`: datapath result index. 31 = invalid.
- `out_letter  out  5`: last captured result.
- `out_valid  out  1`: one-cycle strobe when `out_letter` updates.
- `out_err  out  1`: sticky. Set when a captured `cipher_out` > 25.
- `busy  out  1`: high in every state except IDLE.
- `char_count  out  16`: saturating count of captured letters.

## Operation
- Valid key: `key_ready`=1 and `key_in` exactly one-hot. Zero or multi-hot is not valid.
- `key_prev` is a registered copy of "valid key". It resets to 1, so a key held through reset is not treated as an event.
- Key event: valid key now and `key_prev`=0.
- Letter index: binary encoding of the one-hot `key_in` (0..25).

FSM states: IDLE, STEP, SETTLE, CAPTURE, WAIT_RELEASE.
- IDLE:
  - `cfg_load`=1 has priority. Load positions (any field > 25 loads as 0). A simultaneous key event is discarded. Go to WAIT_RELEASE.
  - Otherwise, on a key event, latch the letter index into `cipher_in` and go to STEP.
- STEP: update rotor positions (rules below), clear the settle counter, go to SETTLE.
- SETTLE: increment the counter. When counter = SETTLE-1, go to CAPTURE.
- CAPTURE:
  - `out_letter` <= `cipher_out`; `out_valid` = 1 the following cycle.
  - `char_count` += 1, saturating at 16'hFFFF.
  - If `cipher_out` > 25, set `out_err`.
  - Go to WAIT_RELEASE.
- WAIT_RELEASE: stay until "valid key" = 0, then go to IDLE.
- `cfg_load` outside IDLE is ignored.

Stepping rules (all evaluated on pre-step values, mod 26, 25 wraps to 0):
- R always steps.
- M steps if R = NOTCH_R, or if M = NOTCH_M (double step).
- L steps if M = NOTCH_M.

## Timing
- Reset values:
  - state IDLE; `pos_l`/`pos_m`/`pos_r`=0; `cipher_in`=0; `cipher_valid`=0;
  - `out_letter`=0; `out_valid`=0; `out_err`=0; `busy`=0; `char_count`=0; `key_prev`=1.
- Latency, with the key event sampled at edge E:
  - STEP is entered at E.
  - Positions update at E+1.
  - Capture occurs at E+2+SETTLE.
  - `out_valid` is high for exactly one cycle, from E+2+SETTLE to E+3+SETTLE.
- With SETTLE=2: positions change after E+1, and `out_valid` is visible after E+4.
- `cipher_in` is stable from E through capture. `cipher_valid` is high from E+1 up to the capture edge.
- Minimum time between results: SETTLE+3 cycles, plus key release plus a new press.
- Reset asserted mid-operation: immediately returns all registers to reset values. No `out_valid` is produced for the interrupted letter.
- `cfg_load` positions are visible on `pos_*` the cycle after the load edge.

## Test plan
- Reset, then press A (`key_in`=1, `key_ready`=1) from 0,0,0:
  - `pos_r`=1, M=0, L=0 after E+1.
  - `cipher_in`=0.
  - With `cipher_out` tied to 7: `out_letter`=7 and a single `out_valid` pulse after E+4. `char_count`=1.
- Carry: load R=16, M=0, L=0, release, press C → R=17, M=1, L=0.
- Double step: load {0,3,16}.
  - Press → {0,4,17}.
  - Release and press → {1,5,18}.
- Wrap: load {25,25,25} with notches moved to 25 via parameters. Press → {0,0,0}.
- Held key and invalid input:
  - Holding A produces exactly one result.
  - Multi-hot `key_in`=3 produces no step.
  - `cipher_out`=31 at capture sets `out_err`=1, which persists until reset.
- Reset and configuration conflicts:
  - Assert reset during SETTLE → no `out_valid`, positions 0, key still held gives no new event.
  - `cfg_load` together with a key event in IDLE → positions loaded, no step.

Source files
------------

// File: rtl/enigma_step_controller_if.sv
// Keyboard / datapath / display bundle for the Enigma step controller.
// master = environment (keyboard, datapath, config), slave = controller.
interface enigma_step_controller_if;
  logic [25:0] key_in;
  logic        key_ready;
  logic        cfg_load;
  logic [14:0] cfg_pos;
  logic [4:0]  pos_l;
  logic [4:0]  pos_m;
  logic [4:0]  pos_r;
  logic [4:0]  cipher_in;
  logic        cipher_valid;
  logic [4:0]  cipher_out;
  logic [4:0]  out_letter;
  logic        out_valid;
  logic        out_err;
  logic        busy;
  logic [15:0] char_count;

  modport master (
    output key_in, key_ready, cfg_load, cfg_pos, cipher_out,
    input  pos_l, pos_m, pos_r, cipher_in, cipher_valid,
           out_letter, out_valid, out_err, busy, char_count
  );

  modport slave (
    input  key_in, key_ready, cfg_load, cfg_pos, cipher_out,
    output pos_l, pos_m, pos_r, cipher_in, cipher_valid,
           out_letter, out_valid, out_err, busy, char_count
  );
endinterface

// File: rtl/enigma_step_controller.sv
// Enigma sequencing controller: detects key presses, steps the three rotors
// (odometer carry plus middle-rotor double step), holds the letter on the
// datapath for SETTLE cycles, then captures the result and strobes it out.
// SETTLE must lie in 1..15 (4-bit settle counter).
module enigma_step_controller #(
  parameter int NOTCH_R = 16,
  parameter int NOTCH_M = 4,
  parameter int SETTLE  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  enigma_step_controller_if.slave   bus
);

  localparam logic [4:0] NOTCH_R_L   = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M_L   = 5'(NOTCH_M);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_SETTLE, S_CAPTURE, S_WAIT_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic        key_prev_q, key_prev_d;
  logic [4:0]  pos_l_q, pos_l_d;
  logic [4:0]  pos_m_q, pos_m_d;
  logic [4:0]  pos_r_q, pos_r_d;
  logic [4:0]  cipher_in_q, cipher_in_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [4:0]  out_letter_q, out_letter_d;
  logic        out_valid_q, out_valid_d;
  logic        out_err_q, out_err_d;
  logic [15:0] char_count_q, char_count_d;

  logic        key_onehot;
  logic        key_valid;
  logic        key_event;
  logic [4:0]  letter_idx;
  logic        busy_o;
  logic        cipher_valid_o;

  // Advance a rotor position modulo 26.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  // Out-of-range configured positions fall back to 0.
  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  assign key_onehot = (bus.key_in != 26'd0) &&
                      ((bus.key_in & (bus.key_in - 26'd1)) == 26'd0);
  assign key_valid  = bus.key_ready & key_onehot;
  // key_prev resets high so a key held across reset is not a new press.
  assign key_event  = key_valid & ~key_prev_q;

  // One-hot to binary letter index; only used when key_in is one-hot.
  always_comb begin
    letter_idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (bus.key_in[i]) letter_idx = letter_idx | 5'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load)   state_d = S_WAIT_RELEASE;
        else if (key_event) state_d = S_STEP;
      end
      S_STEP:    state_d = S_SETTLE;
      S_SETTLE:  if (settle_cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (!key_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    cipher_valid_o = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  end

  // Next values of rotor positions, latched letter, counters and result.
  always_comb begin
    key_prev_d   = key_valid;
    pos_l_d      = pos_l_q;
    pos_m_d      = pos_m_q;
    pos_r_d      = pos_r_q;
    cipher_in_d  = cipher_in_q;
    settle_cnt_d = settle_cnt_q;
    out_letter_d = out_letter_q;
    out_valid_d  = 1'b0;
    out_err_d    = out_err_q;
    char_count_d = char_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load) begin
          // Configuration wins; a simultaneous press is dropped.
          pos_l_d = clamp26(bus.cfg_pos[14:10]);
          pos_m_d = clamp26(bus.cfg_pos[9:5]);
          pos_r_d = clamp26(bus.cfg_pos[4:0]);
        end else if (key_event) begin
          cipher_in_d = letter_idx;
        end
      end
      S_STEP: begin
        // All step decisions use the pre-step positions.
        pos_r_d = inc26(pos_r_q);
        if ((pos_r_q == NOTCH_R_L) || (pos_m_q == NOTCH_M_L))
          pos_m_d = inc26(pos_m_q);
        if (pos_m_q == NOTCH_M_L)
          pos_l_d = inc26(pos_l_q);
        settle_cnt_d = 4'd0;
      end
      S_SETTLE: settle_cnt_d = settle_cnt_q + 4'd1;
      S_CAPTURE: begin
        out_letter_d = bus.cipher_out;
        out_valid_d  = 1'b1;
        if (char_count_q != 16'hFFFF) char_count_d = char_count_q + 16'd1;
        if (bus.cipher_out > 5'd25)   out_err_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_prev_q   <= 1'b1;
      pos_l_q      <= 5'd0;
      pos_m_q      <= 5'd0;
      pos_r_q      <= 5'd0;
      cipher_in_q  <= 5'd0;
      settle_cnt_q <= 4'd0;
      out_letter_q <= 5'd0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      char_count_q <= 16'd0;
    end else begin
      key_prev_q   <= key_prev_d;
      pos_l_q      <= pos_l_d;
      pos_m_q      <= pos_m_d;
      pos_r_q      <= pos_r_d;
      cipher_in_q  <= cipher_in_d;
      settle_cnt_q <= settle_cnt_d;
      out_letter_q <= out_letter_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      char_count_q <= char_count_d;
    end
  end

  assign bus.pos_l        = pos_l_q;
  assign bus.pos_m        = pos_m_q;
  assign bus.pos_r        = pos_r_q;
  assign bus.cipher_in    = cipher_in_q;
  assign bus.cipher_valid = cipher_valid_o;
  assign bus.out_letter   = out_letter_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_err      = out_err_q;
  assign bus.busy         = busy_o;
  assign bus.char_count   = char_count_q;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Self-checking bench for enigma_step_controller: table-driven key presses
// with a result scoreboard, plus hand-written latency/reset/config sequences.
module tb_enigma_step_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  enigma_step_controller_if bus();
  enigma_step_controller_if bus_w();

  enigma_step_controller #(.NOTCH_R(16), .NOTCH_M(4), .SETTLE(2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  enigma_step_controller #(.NOTCH_R(25), .NOTCH_M(25), .SETTLE(2)) dut_wrap (
    .clock(clock), .reset(reset), .bus(bus_w)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [4:0]  sb_q[$];
  logic [15:0] exp_count = 16'd0;

  typedef struct {
    logic        load;
    logic [14:0] cfg;
    logic [14:0] exp_load;
    int          letter;
    logic [4:0]  cout;
    logic [14:0] exp_pos;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("[TB] ok %s = %0d", name, actual);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_pos(input string name, input logic [14:0] exp_p);
    check(name, int'({bus.pos_l, bus.pos_m, bus.pos_r}), int'(exp_p));
  endtask

  task automatic release_key();
    bus.key_in    = 26'd0;
    bus.key_ready = 1'b0;
    tick(2);
  endtask

  task automatic load_pos(input logic [14:0] p, input logic [14:0] exp_p);
    bus.cfg_load = 1'b1;
    bus.cfg_pos  = p;
    tick(1);
    check_pos("load_pos", exp_p);
    bus.cfg_load = 1'b0;
    tick(2);
    check("load_idle", int'(bus.busy), 0);
  endtask

  // Press a key, expect a result of cout, then check stepped positions.
  task automatic press(input int letter, input logic [4:0] cout,
                       input logic [14:0] exp_p, input string name);
    bus.key_in     = 26'd1 << letter;
    bus.key_ready  = 1'b1;
    bus.cipher_out = cout;
    sb_q.push_back(cout);
    tick(7);
    check_pos(name, exp_p);
    check("cipher_in", int'(bus.cipher_in), letter);
    check("busy_held", int'(bus.busy), 1);
    release_key();
    check("busy_released", int'(bus.busy), 0);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (reset) begin
      exp_count = 16'd0;
    end else if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [4:0] exp_letter;
        exp_letter = sb_q.pop_front();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        check("sb_out_letter", int'(bus.out_letter), int'(exp_letter));
        check("sb_char_count", int'(bus.char_count), int'(exp_count));
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, {5'd0, 5'd0, 5'd16},   {5'd0, 5'd0, 5'd16},   2,  5'd5,  {5'd0, 5'd1, 5'd17}};
    vecs[1] = '{1'b1, {5'd0, 5'd3, 5'd16},   {5'd0, 5'd3, 5'd16},   3,  5'd10, {5'd0, 5'd4, 5'd17}};
    vecs[2] = '{1'b0, 15'd0,                 15'd0,                 4,  5'd0,  {5'd1, 5'd5, 5'd18}};
    vecs[3] = '{1'b1, {5'd25, 5'd25, 5'd25}, {5'd25, 5'd25, 5'd25}, 24, 5'd25, {5'd25, 5'd25, 5'd0}};
    vecs[4] = '{1'b1, {5'd26, 5'd30, 5'd31}, 15'd0,                 25, 5'd12, {5'd0, 5'd0, 5'd1}};
    vecs[5] = '{1'b1, {5'd10, 5'd4, 5'd3},   {5'd10, 5'd4, 5'd3},   9,  5'd3,  {5'd11, 5'd5, 5'd4}};
    vecs[6] = '{1'b0, 15'd0,                 15'd0,                 1,  5'd20, {5'd11, 5'd5, 5'd5}};
    vecs[7] = '{1'b1, {5'd0, 5'd15, 5'd16},  {5'd0, 5'd15, 5'd16},  12, 5'd1,  {5'd0, 5'd16, 5'd17}};

    // Key A held through reset.
    bus.key_in       = 26'd1;
    bus.key_ready    = 1'b1;
    bus.cfg_load     = 1'b0;
    bus.cfg_pos      = 15'd0;
    bus.cipher_out   = 5'd7;
    bus_w.key_in     = 26'd0;
    bus_w.key_ready  = 1'b0;
    bus_w.cfg_load   = 1'b0;
    bus_w.cfg_pos    = 15'd0;
    bus_w.cipher_out = 5'd0;
    reset = 1'b1;
    tick(2);
    check_pos("rst_pos", 15'd0);
    check("rst_cipher_in", int'(bus.cipher_in), 0);
    check("rst_cipher_valid", int'(bus.cipher_valid), 0);
    check("rst_out_letter", int'(bus.out_letter), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_char_count", int'(bus.char_count), 0);
    reset = 1'b0;
    tick(5);
    check("held_through_reset_busy", int'(bus.busy), 0);
    check_pos("held_through_reset_pos", 15'd0);
    release_key();

    // First press from 0,0,0 with exact latency checks.
    bus.key_in     = 26'd1;
    bus.key_ready  = 1'b1;
    bus.cipher_out = 5'd7;
    sb_q.push_back(5'd7);
    tick(1);
    check("e0_busy", int'(bus.busy), 1);
    check("e0_cipher_valid", int'(bus.cipher_valid), 0);
    check("e0_pos_r", int'(bus.pos_r), 0);
    tick(1);
    check_pos("e1_pos", {5'd0, 5'd0, 5'd1});
    check("e1_cipher_valid", int'(bus.cipher_valid), 1);
    check("e1_cipher_in", int'(bus.cipher_in), 0);
    tick(2);
    check("e3_out_valid", int'(bus.out_valid), 0);
    check("e3_cipher_valid", int'(bus.cipher_valid), 1);
    tick(1);
    check("e4_out_valid", int'(bus.out_valid), 1);
    check("e4_cipher_valid", int'(bus.cipher_valid), 0);
    tick(1);
    check("e5_out_valid", int'(bus.out_valid), 0);
    tick(20);
    check("held_key_count", int'(bus.char_count), 1);
    release_key();

    // Table-driven presses.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].load) load_pos(vecs[i].cfg, vecs[i].exp_load);
      press(vecs[i].letter, vecs[i].cout, vecs[i].exp_pos, $sformatf("vec%0d_pos", i));
    end

    // Multi-hot and not-ready keys give no step.
    bus.key_in    = 26'd3;
    bus.key_ready = 1'b1;
    tick(6);
    check("multihot_busy", int'(bus.busy), 0);
    check_pos("multihot_pos", {5'd0, 5'd16, 5'd17});
    bus.key_in    = 26'd1;
    bus.key_ready = 1'b0;
    tick(4);
    check("notready_busy", int'(bus.busy), 0);
    bus.key_in = 26'd0;
    tick(2);

    // Invalid datapath result sets the sticky error.
    press(7, 5'd31, {5'd0, 5'd16, 5'd18}, "err_pos");
    check("out_err_set", int'(bus.out_err), 1);
    press(8, 5'd4, {5'd0, 5'd16, 5'd19}, "err_next_pos");
    check("out_err_sticky", int'(bus.out_err), 1);

    // cfg_load outside IDLE is ignored.
    bus.key_in     = 26'd1 << 5;
    bus.key_ready  = 1'b1;
    bus.cipher_out = 5'd9;
    sb_q.push_back(5'd9);
    tick(3);
    bus.cfg_load = 1'b1;
    bus.cfg_pos  = {5'd5, 5'd5, 5'd5};
    tick(1);
    bus.cfg_load = 1'b0;
    tick(4);
    check_pos("busy_cfg_ignored", {5'd0, 5'd16, 5'd20});
    release_key();

    // Reset during SETTLE: no result, key still held gives no new event.
    bus.key_in     = 26'd1 << 6;
    bus.key_ready  = 1'b1;
    bus.cipher_out = 5'd2;
    tick(2);
    check("pre_reset_cipher_valid", int'(bus.cipher_valid), 1);
    reset = 1'b1;
    #1;
    check_pos("async_reset_pos", 15'd0);
    check("async_reset_busy", int'(bus.busy), 0);
    tick(1);
    reset = 1'b0;
    tick(8);
    check("post_reset_busy", int'(bus.busy), 0);
    check_pos("post_reset_pos", 15'd0);
    check("post_reset_count", int'(bus.char_count), 0);
    check("post_reset_err", int'(bus.out_err), 0);
    release_key();

    // cfg_load together with a key event: load wins, no step.
    bus.cfg_load  = 1'b1;
    bus.cfg_pos   = {5'd1, 5'd2, 5'd3};
    bus.key_in    = 26'd1;
    bus.key_ready = 1'b1;
    tick(1);
    check_pos("cfg_key_load", {5'd1, 5'd2, 5'd3});
    bus.cfg_load = 1'b0;
    tick(8);
    check_pos("cfg_key_nostep", {5'd1, 5'd2, 5'd3});
    release_key();
    check("cfg_key_idle", int'(bus.busy), 0);
    press(1, 5'd11, {5'd1, 5'd2, 5'd4}, "after_cfg_pos");

    // Full wrap with both notches at 25.
    bus_w.cfg_load = 1'b1;
    bus_w.cfg_pos  = {5'd25, 5'd25, 5'd25};
    tick(1);
    check("wrap_load", int'({bus_w.pos_l, bus_w.pos_m, bus_w.pos_r}), int'({5'd25, 5'd25, 5'd25}));
    bus_w.cfg_load = 1'b0;
    tick(2);
    bus_w.key_in    = 26'd1;
    bus_w.key_ready = 1'b1;
    tick(7);
    check("wrap_pos", int'({bus_w.pos_l, bus_w.pos_m, bus_w.pos_r}), 0);
    check("wrap_count", int'(bus_w.char_count), 1);
    bus_w.key_in    = 26'd0;
    bus_w.key_ready = 1'b0;
    tick(3);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
